// File: rtl/div_rem_issue.sv
// Core-side front end for the multi-cycle unsigned divider: resolves RV32M
// corner cases locally, issues unsigned magnitudes, and restores the result sign.
module div_rem_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        kill,
  output logic        ready,
  output logic        valid,
  output logic [31:0] result,
  output logic        order,
  input  logic        accepted,
  input  logic        done,
  output logic [31:0] u_rs1,
  output logic [31:0] u_rs2,
  output logic        rem_flag,
  input  logic [31:0] unit_rd
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FIX} state_t;

  state_t      state;
  logic [31:0] src1_q;
  logic        div0_q;
  logic        neg_q;

  // Request decode, only meaningful while IDLE samples exec.
  logic        is_signed;
  logic        div0;
  logic        ovf;
  logic        neg;
  logic [31:0] mag1;
  logic [31:0] mag2;

  assign is_signed = ~op[0];
  assign div0      = (src2 == 32'd0);
  assign ovf       = is_signed && (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  assign neg       = is_signed & (op[1] ? src1[31] : (src1[31] ^ src2[31]));
  assign mag1      = (is_signed & src1[31]) ? (~src1 + 32'd1) : src1;
  assign mag2      = (is_signed & src2[31]) ? (~src2 + 32'd1) : src2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      result   <= '0;
      order    <= 1'b0;
      u_rs1    <= '0;
      u_rs2    <= '0;
      rem_flag <= 1'b0;
      src1_q   <= '0;
      div0_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      // NOTE: all state here uses <= so every branch sees the pre-edge values;
      // a blocking write would leak into later reads within this same block.
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (exec && !kill) begin
            rem_flag <= op[1];
            u_rs1    <= mag1;
            u_rs2    <= mag2;
            src1_q   <= src1;
            div0_q   <= div0;
            neg_q    <= neg;
            ready    <= 1'b0;
            if (div0 || ovf) begin
              state <= FIX;
            end else begin
              state <= ISSUE;
              order <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accepted) begin
            order <= 1'b0;
            state <= kill ? DRAIN : WAIT;
          end else if (kill) begin
            order <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
            ready <= 1'b1;
            if (!kill) begin
              valid  <= 1'b1;
              result <= neg_q ? (~unit_rd + 32'd1) : unit_rd;
            end
          end else if (kill) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          ready <= 1'b1;
          if (!kill) begin
            valid <= 1'b1;
            if (div0_q) result <= rem_flag ? src1_q : 32'hFFFF_FFFF;
            else        result <= rem_flag ? 32'd0 : 32'h8000_0000;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          order <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_rem_issue.md
# div_rem_issue

Core-side initiator for the multi-cycle unsigned divide/remainder unit. Accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage. Resolves divide-by-zero and signed overflow locally; otherwise converts operands to unsigned magnitudes and drives the unit's order/accepted/done handshake. Restores the RISC-V result sign and returns one registered result per request.

## Interface
Parameters:
- none (word width fixed at 32)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- exec  in  1  request strobe; sampled only when ready=1
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- src1  in  32  dividend
- src2  in  32  divisor
- kill  in  1  discard the in-flight request (pipeline flush)
- ready  out  1  high only in IDLE
- valid  out  1  one-cycle result strobe
- result  out  32  result; held stable until the next valid
- order  out  1  request to unit
- accepted  in  1  unit took the request this cycle
- done  in  1  unit result present on unit_rd this cycle
- u_rs1  out  32  unsigned dividend to unit
- u_rs2  out  32  unsigned divisor to unit
- rem_flag  out  1  1 selects remainder from unit
- unit_rd  in  32  unit result
- The unit's active-low reset is tied to ~rst at integration.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, FIX.
- IDLE, exec=1:
  - latch op, src1, src2.
  - signed = ~op[0]; rem_flag = op[1].
  - Special cases go to FIX: src2==0, or signed with src1==0x80000000 and src2==0xFFFFFFFF.
  - Otherwise go to ISSUE.
- FIX computes the result without touching the unit:
  - div-by-zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> src1.
  - overflow: DIV -> 0x80000000; REM -> 0.
  - valid=1 for one cycle, then IDLE.
- ISSUE: order=1.
  - u_rs1 = signed&src1[31] ? -src1 : src1; u_rs2 likewise from src2.
  - u_rs1, u_rs2, rem_flag held constant until the unit returns done.
  - accepted=1 -> WAIT; order drops the following cycle.
- WAIT: on done, capture unit_rd and apply the sign fix. Go to IDLE; result and valid update on the same edge.
  - quotient negated if signed and src1[31]^src2[31].
  - remainder negated if signed and src1[31].
- kill handling:
  - in ISSUE with accepted=0: go to IDLE, no valid, order drops next cycle.
  - in ISSUE with accepted=1, or in WAIT: go to DRAIN. DRAIN waits for done, discards unit_rd, goes to IDLE with no valid.
  - in FIX: valid suppressed.
  - kill in IDLE is ignored, and exec in the same cycle is ignored as well.
- done observed in IDLE, ISSUE or FIX is a protocol error. It is ignored; verification asserts that it never happens.
- All arithmetic is mod 2^32. Negation is two's complement. -0x80000000 yields 0x80000000, which is the correct unsigned magnitude.

## Timing
- Reset values: state=IDLE, ready=1, valid=0, result=0, order=0, u_rs1=0, u_rs2=0, rem_flag=0.
- rst asserted in any state returns to IDLE on that edge. Any unit request is abandoned, and the unit is reset together with this block.
- Special case: exec at cycle 0 -> FIX at cycle 1 -> valid=1 at cycle 2 -> ready=1 at cycle 2.
- Normal case:
  - exec at cycle 0 -> order=1 from cycle 1.
  - With accepted at cycle 1 and unit latency L (done at cycle 1+L, L>=1): valid=1 at cycle 2+L, ready=1 at cycle 2+L.
- Each cycle accepted=0 while order=1 adds one cycle. Operands must not change during the stall.
- order is never asserted outside ISSUE and never reasserted in the cycle following accepted.
- At most one request outstanding; exec while ready=0 is ignored, not queued.
- valid is high exactly one cycle per non-killed request. result is unchanged between valid pulses.

## Test plan
- DIV src1=0xFFFFFFF9 (-7), src2=2:
  - u_rs1=7, u_rs2=2, rem_flag=0 while order=1.
  - result=0xFFFFFFFD.
  - REM with the same operands -> result 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0 -> order never asserted, valid at cycle 2, result=0xFFFFFFFF. REMU 5/0 -> result=5.
- DIV 0x80000000 / 0xFFFFFFFF -> no order, result=0x80000000. REM with the same operands -> result 0.
- REMU 100/7 with accepted held low 3 cycles:
  - order high 4 cycles, u_rs1=100 stable throughout.
  - result=2 one cycle after done.
- DIVU 1000/10 with kill asserted in WAIT:
  - state DRAIN, valid never asserted, ready stays 0 until the cycle after done.
  - A following exec completes normally.
- rst pulsed mid-WAIT -> next cycle order=0, valid=0, ready=1, result=0. A late done is ignored.
